// File: rtl/shift_operand_stage_if.sv
// Handshake, writeback and shifter-input bundle for shift_operand_stage.
interface shift_operand_stage_if #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
);
  localparam int IDX_W = $clog2(NREGS);

  logic              InValid;
  logic              InReady;
  logic [2:0]        InSelect;
  logic [IDX_W-1:0]  InRegB;
  logic              InAmtImm;
  logic [3:0]        InAmount;
  logic [IDX_W-1:0]  InRegAmt;
  logic [IDX_W-1:0]  InDest;

  logic              WbValid;
  logic [IDX_W-1:0]  WbDest;
  logic [DATA_W-1:0] WbData;

  logic              OutValid;
  logic              OutReady;
  logic [2:0]        ShiftSelect;
  logic [3:0]        ShifterAmount;
  logic [DATA_W-1:0] originB;
  logic [IDX_W-1:0]  OutDest;

  modport master (
    output InValid, InSelect, InRegB, InAmtImm, InAmount, InRegAmt, InDest,
    output WbValid, WbDest, WbData, OutReady,
    input  InReady, OutValid, ShiftSelect, ShifterAmount, originB, OutDest
  );

  modport slave (
    input  InValid, InSelect, InRegB, InAmtImm, InAmount, InRegAmt, InDest,
    input  WbValid, WbDest, WbData, OutReady,
    output InReady, OutValid, ShiftSelect, ShifterAmount, originB, OutDest
  );
endinterface

// File: rtl/shift_operand_stage.sv
// Operand-issue stage for the barrel shifter: 1-cycle accept-to-output latency,
// InReady drops on a full output stage without OutReady or on a scoreboard hazard.
module shift_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input logic clk,
  input logic rst_n,
  shift_operand_stage_if.slave bus
);
  localparam int IDX_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;

  logic              out_vld_q, out_vld_d;
  logic [2:0]        sel_q, sel_d;
  logic [3:0]        amt_q, amt_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [IDX_W-1:0]  dest_q, dest_d;

  logic [DATA_W-1:0] rd_b, rd_amt;
  logic [3:0]        amt_res;
  logic              wb_hit_b, wb_hit_amt, wb_hit_dest;
  logic              hazard, in_rdy, accept;

  always_comb begin
    wb_hit_b    = bus.WbValid && (bus.WbDest == bus.InRegB);
    wb_hit_amt  = bus.WbValid && (bus.WbDest == bus.InRegAmt);
    wb_hit_dest = bus.WbValid && (bus.WbDest == bus.InDest);

    rd_b    = wb_hit_b   ? bus.WbData : regs_q[bus.InRegB];
    rd_amt  = wb_hit_amt ? bus.WbData : regs_q[bus.InRegAmt];
    amt_res = bus.InAmtImm ? bus.InAmount : rd_amt[3:0];

    // A writeback landing this cycle resolves the dependency through the bypass.
    hazard = (pending_q[bus.InRegB] && !wb_hit_b)
          || (!bus.InAmtImm && pending_q[bus.InRegAmt] && !wb_hit_amt)
          || (pending_q[bus.InDest] && !wb_hit_dest);

    in_rdy = (!out_vld_q || bus.OutReady) && !hazard;
    accept = bus.InValid && in_rdy;
  end

  always_comb begin
    pending_d = pending_q;
    if (bus.WbValid) pending_d[bus.WbDest] = 1'b0;
    if (accept)      pending_d[bus.InDest] = 1'b1;

    out_vld_d = out_vld_q;
    sel_d     = sel_q;
    amt_d     = amt_q;
    b_d       = b_q;
    dest_d    = dest_q;
    if (accept) begin
      out_vld_d = 1'b1;
      sel_d     = bus.InSelect;
      amt_d     = amt_res;
      b_d       = rd_b;
      dest_d    = bus.InDest;
    end else if (bus.OutReady) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
      out_vld_q <= 1'b0;
      sel_q     <= '0;
      amt_q     <= '0;
      b_q       <= '0;
      dest_q    <= '0;
    end else begin
      if (bus.WbValid) regs_q[bus.WbDest] <= bus.WbData;
      pending_q <= pending_d;
      out_vld_q <= out_vld_d;
      sel_q     <= sel_d;
      amt_q     <= amt_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
    end
  end

  assign bus.InReady       = in_rdy;
  assign bus.OutValid      = out_vld_q;
  assign bus.ShiftSelect   = sel_q;
  assign bus.ShifterAmount = amt_q;
  assign bus.originB       = b_q;
  assign bus.OutDest       = dest_q;
endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed vector bench for shift_operand_stage.
module tb_shift_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_operand_stage_if #(.DATA_W(16), .NREGS(8)) bus ();

  shift_operand_stage #(.DATA_W(16), .NREGS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        wv;
    logic [2:0]  wd;
    logic [15:0] wdat;
    logic        iv;
    logic [2:0]  sel;
    logic [2:0]  regb;
    logic        imm;
    logic [3:0]  amt;
    logic [2:0]  regamt;
    logic [2:0]  dest;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [2:0]  e_sel;
    logic [3:0]  e_amt;
    logic [15:0] e_b;
    logic [2:0]  e_dest;
  } vec_t;

  function automatic vec_t mk(
    input logic wv, input logic [2:0] wd, input logic [15:0] wdat,
    input logic iv, input logic [2:0] sel, input logic [2:0] regb,
    input logic imm, input logic [3:0] amt, input logic [2:0] regamt,
    input logic [2:0] dest, input logic ordy,
    input logic e_rdy, input logic e_vld, input logic [2:0] e_sel,
    input logic [3:0] e_amt, input logic [15:0] e_b, input logic [2:0] e_dest);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wdat = wdat;
    v.iv = iv; v.sel = sel; v.regb = regb; v.imm = imm; v.amt = amt;
    v.regamt = regamt; v.dest = dest; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_sel = e_sel; v.e_amt = e_amt;
    v.e_b = e_b; v.e_dest = e_dest;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.WbValid  = v.wv;
    bus.WbDest   = v.wd;
    bus.WbData   = v.wdat;
    bus.InValid  = v.iv;
    bus.InSelect = v.sel;
    bus.InRegB   = v.regb;
    bus.InAmtImm = v.imm;
    bus.InAmount = v.amt;
    bus.InRegAmt = v.regamt;
    bus.InDest   = v.dest;
    bus.OutReady = v.ordy;
  endtask

  // Drive one cycle, check InReady mid-cycle, then check outputs just after the edge.
  task automatic run_vec(input string nm, input int idx, input vec_t v);
    drive(v);
    @(negedge clk);
    chk({nm, ".InReady"}, idx, 32'(bus.InReady), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({nm, ".OutValid"}, idx, 32'(bus.OutValid), 32'(v.e_vld));
    chk({nm, ".ShiftSelect"}, idx, 32'(bus.ShiftSelect), 32'(v.e_sel));
    chk({nm, ".ShifterAmount"}, idx, 32'(bus.ShifterAmount), 32'(v.e_amt));
    chk({nm, ".originB"}, idx, 32'(bus.originB), 32'(v.e_b));
    chk({nm, ".OutDest"}, idx, 32'(bus.OutDest), 32'(v.e_dest));
  endtask

  vec_t tbl [11];
  vec_t v;

  initial begin
    //          wv wd  wdat      iv sel   regb imm amt   ramt dest ordy  rdy vld esel  eamt  eb         edest
    tbl[0]  = mk(1, 2, 16'h8001, 0, 3'd0, 3'd0, 1, 4'd0, 3'd0, 3'd0, 1,  1, 0, 3'd0, 4'd0, 16'h0000, 3'd0);
    tbl[1]  = mk(1, 5, 16'h00F7, 1, 3'd2, 3'd2, 1, 4'd4, 3'd0, 3'd3, 1,  1, 1, 3'd2, 4'd4, 16'h8001, 3'd3);
    tbl[2]  = mk(1, 3, 16'h0055, 1, 3'd1, 3'd0, 0, 4'd0, 3'd5, 3'd6, 1,  1, 1, 3'd1, 4'd7, 16'h0000, 3'd6);
    tbl[3]  = mk(1, 1, 16'h1234, 1, 3'd3, 3'd1, 1, 4'hF, 3'd0, 3'd7, 1,  1, 1, 3'd3, 4'hF, 16'h1234, 3'd7);
    tbl[4]  = mk(1, 6, 16'hBEEF, 1, 3'd7, 3'd6, 1, 4'd1, 3'd0, 3'd0, 1,  1, 1, 3'd7, 4'd1, 16'hBEEF, 3'd0);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 3'd0, 3'd1, 1, 4'd0, 3'd0, 3'd2, 1,  1, 0, 3'd7, 4'd1, 16'hBEEF, 3'd0);
    tbl[6]  = mk(0, 0, 16'h0000, 1, 3'd2, 3'd1, 1, 4'd5, 3'd0, 3'd7, 1,  0, 0, 3'd7, 4'd1, 16'hBEEF, 3'd0);
    tbl[7]  = mk(0, 0, 16'h0000, 1, 3'd2, 3'd1, 0, 4'd5, 3'd0, 3'd2, 1,  0, 0, 3'd7, 4'd1, 16'hBEEF, 3'd0);
    tbl[8]  = mk(1, 7, 16'h0003, 1, 3'd4, 3'd7, 0, 4'd0, 3'd7, 3'd7, 1,  1, 1, 3'd4, 4'd3, 16'h0003, 3'd7);
    tbl[9]  = mk(1, 0, 16'h0A0A, 0, 3'd0, 3'd7, 1, 4'd0, 3'd0, 3'd1, 1,  0, 0, 3'd4, 4'd3, 16'h0003, 3'd7);
    tbl[10] = mk(1, 7, 16'h7777, 1, 3'd5, 3'd0, 1, 4'd2, 3'd0, 3'd5, 1,  1, 1, 3'd5, 4'd2, 16'h0A0A, 3'd5);

    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset.OutValid", 0, 32'(bus.OutValid), 32'd0);
    chk("reset.ShiftSelect", 0, 32'(bus.ShiftSelect), 32'd0);
    chk("reset.ShifterAmount", 0, 32'(bus.ShifterAmount), 32'd0);
    chk("reset.originB", 0, 32'(bus.originB), 32'd0);
    chk("reset.OutDest", 0, 32'(bus.OutDest), 32'd0);

    for (int i = 0; i < 11; i++) run_vec("tbl", i, tbl[i]);

    // RAW stall: Dest=4 issued, dependent instruction waits for the R4 writeback.
    run_vec("raw_src", 0, mk(0, 0, 0, 1, 3'd0, 3'd2, 1, 4'd1, 3'd0, 3'd4, 1,
                             1, 1, 3'd0, 4'd1, 16'h8001, 3'd4));
    for (int i = 0; i < 3; i++)
      run_vec("raw_stall", i, mk(0, 0, 0, 1, 3'd2, 3'd4, 1, 4'd3, 3'd0, 3'd3, 1,
                                 0, 0, 3'd0, 4'd1, 16'h8001, 3'd4));
    run_vec("raw_wb", 0, mk(1, 4, 16'hABCD, 1, 3'd2, 3'd4, 1, 4'd3, 3'd0, 3'd3, 1,
                            1, 1, 3'd2, 4'd3, 16'hABCD, 3'd3));

    // Backpressure: outputs frozen while OutReady is low, queued instruction enters when it rises.
    for (int i = 0; i < 3; i++)
      run_vec("bp_hold", i, mk(0, 0, 0, 1, 3'd6, 3'd1, 1, 4'd9, 3'd0, 3'd2, 0,
                               0, 1, 3'd2, 4'd3, 16'hABCD, 3'd3));
    run_vec("bp_release", 0, mk(0, 0, 0, 1, 3'd6, 3'd1, 1, 4'd9, 3'd0, 3'd2, 1,
                                1, 1, 3'd6, 4'd9, 16'h1234, 3'd2));

    // Mid-operation reset with pending[3] set and a writeback to R3 that must be dropped.
    drive(mk(1, 3, 16'h5555, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst.OutValid", 0, 32'(bus.OutValid), 32'd0);
    chk("midrst.originB", 0, 32'(bus.originB), 32'd0);
    chk("midrst.ShiftSelect", 0, 32'(bus.ShiftSelect), 32'd0);
    run_vec("midrst_issue", 0, mk(0, 0, 0, 1, 3'd1, 3'd3, 1, 4'd0, 3'd0, 3'd1, 1,
                                  1, 1, 3'd1, 4'd0, 16'h0000, 3'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
